// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall vector layout, stop encodings, NOP payload and counter width.
package pipe_pkg;

  localparam int unsigned STALL_W_DEF = 6;
  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IF    = 1;
  localparam int unsigned STALL_ID    = 2;
  localparam int unsigned STALL_EX    = 3;
  localparam int unsigned STALL_MEM   = 4;
  localparam int unsigned STALL_WB    = 5;

  localparam logic STOP     = 1'b1;
  localparam logic NOT_STOP = 1'b0;

  localparam int unsigned PAYLOAD_W_DEF = 64;
  localparam logic [PAYLOAD_W_DEF-1:0] NOP_PAYLOAD = '0;

  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous active-high reset.
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid, flush, multicycle parking and stall handling.
// Define PIPE_PERF_CNT_EN to build the bubble/hold performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int unsigned INST_W    = 32,
  parameter int unsigned MC_W      = 66,
  parameter int unsigned STALL_W   = STALL_W_DEF,
  parameter int unsigned STAGE_IDX = STALL_EX,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 up_valid,
  input  logic [PAYLOAD_W-1:0] up_payload,
  input  logic [INST_W-1:0]    up_inst,
  input  logic [MC_W-1:0]      up_mc_state,
  output logic                 dn_valid,
  output logic [PAYLOAD_W-1:0] dn_payload,
  output logic [INST_W-1:0]    dn_inst,
  output logic [MC_W-1:0]      mc_state_o,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     hold_cnt
);

  if (STAGE_IDX + 1 >= STALL_W) begin : g_stage_idx_chk
    $error("pipe_stage_reg: STAGE_IDX+1 must be below STALL_W");
  end

  logic up_stop;
  logic dn_stop;
  logic is_bubble;
  logic is_hold;

  logic                 valid_nxt;
  logic [PAYLOAD_W-1:0] payload_nxt;
  logic [INST_W-1:0]    inst_nxt;
  logic [MC_W-1:0]      mc_nxt;

  assign up_stop   = stall[STAGE_IDX];
  assign dn_stop   = stall[STAGE_IDX+1];
  assign is_bubble = !flush && (up_stop == STOP) && (dn_stop == NOT_STOP);
  assign is_hold   = !flush && (up_stop == STOP) && (dn_stop == STOP);

  // Only two stall bits matter to this stage.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Next-state priority: flush, bubble, advance, hold (hold keeps dn_* by default).
  always_comb begin
    valid_nxt   = dn_valid;
    payload_nxt = dn_payload;
    inst_nxt    = dn_inst;
    mc_nxt      = up_mc_state;
    if (flush) begin
      valid_nxt   = 1'b0;
      payload_nxt = PAYLOAD_W'(NOP_PAYLOAD);
      inst_nxt    = '0;
      mc_nxt      = '0;
    end else if (is_bubble) begin
      valid_nxt   = 1'b0;
      payload_nxt = PAYLOAD_W'(NOP_PAYLOAD);
      inst_nxt    = up_inst;
    end else if (up_stop == NOT_STOP) begin
      // Also covers the never-generated !up_stop & dn_stop pattern.
      valid_nxt   = up_valid;
      payload_nxt = up_payload;
      inst_nxt    = up_inst;
      mc_nxt      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid   <= 1'b0;
      dn_payload <= '0;
      dn_inst    <= '0;
      mc_state_o <= '0;
    end else begin
      dn_valid   <= valid_nxt;
      dn_payload <= payload_nxt;
      dn_inst    <= inst_nxt;
      mc_state_o <= mc_nxt;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (is_bubble),
    .cnt (bubble_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .inc (is_hold),
    .cnt (hold_cnt)
  );
`else
  logic unused_perf;
  assign unused_perf = is_bubble ^ is_hold;
  assign bubble_cnt  = '0;
  assign hold_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg with a behavioural stage model; honours PIPE_PERF_CNT_EN.
module tb_pipe_stage_reg;

  localparam int unsigned PAYLOAD_W = 64;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned MC_W      = 66;
  localparam int unsigned STALL_W   = 6;
  localparam int unsigned CNT_W     = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [STALL_W-1:0]   stall;
  logic                 flush;
  logic                 up_valid;
  logic [PAYLOAD_W-1:0] up_payload;
  logic [INST_W-1:0]    up_inst;
  logic [MC_W-1:0]      up_mc_state;
  logic                 dn_valid;
  logic [PAYLOAD_W-1:0] dn_payload;
  logic [INST_W-1:0]    dn_inst;
  logic [MC_W-1:0]      mc_state_o;
  logic [CNT_W-1:0]     bubble_cnt;
  logic [CNT_W-1:0]     hold_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic                 m_valid;
  logic [PAYLOAD_W-1:0] m_payload;
  logic [INST_W-1:0]    m_inst;
  logic [MC_W-1:0]      m_mc;
  int                   m_bub;
  int                   m_hold;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .PAYLOAD_W (PAYLOAD_W),
    .INST_W    (INST_W),
    .MC_W      (MC_W),
    .STALL_W   (STALL_W),
    .STAGE_IDX (3),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .up_valid    (up_valid),
    .up_payload  (up_payload),
    .up_inst     (up_inst),
    .up_mc_state (up_mc_state),
    .dn_valid    (dn_valid),
    .dn_payload  (dn_payload),
    .dn_inst     (dn_inst),
    .mc_state_o  (mc_state_o),
    .bubble_cnt  (bubble_cnt),
    .hold_cnt    (hold_cnt)
  );

  function automatic int exp_bub();
`ifdef PIPE_PERF_CNT_EN
    return m_bub;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_hold();
`ifdef PIPE_PERF_CNT_EN
    return m_hold;
`else
    return 0;
`endif
  endfunction

  // Stage behaviour as stated: reset, flush, bubble, advance, hold.
  task automatic model_edge();
    bit us, ds;
    us = stall[3];
    ds = stall[4];
    if (rst) begin
      m_valid = 0; m_payload = '0; m_inst = '0; m_mc = '0; m_bub = 0; m_hold = 0;
    end else if (flush) begin
      m_valid = 0; m_payload = '0; m_inst = '0; m_mc = '0;
    end else if (us && !ds) begin
      m_valid = 0; m_payload = '0; m_inst = up_inst; m_mc = up_mc_state;
      m_bub = (m_bub < CNT_MAX) ? m_bub + 1 : CNT_MAX;
    end else if (!us) begin
      m_valid = up_valid; m_payload = up_payload; m_inst = up_inst; m_mc = '0;
    end else begin
      m_mc = up_mc_state;
      m_hold = (m_hold < CNT_MAX) ? m_hold + 1 : CNT_MAX;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    up_payload = '1; up_valid = 1'b1; up_inst = '1; up_mc_state = '1;
    stall = '0; flush = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if ({dn_valid, dn_payload, dn_inst, mc_state_o, bubble_cnt, hold_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_first_edge: got v=%0b p=%h i=%h mc=%h b=%0d h=%0d, expected all 0",
               dn_valid, dn_payload, dn_inst, mc_state_o, bubble_cnt, hold_cnt);
    end
    tick();
    checks++;
    if ({dn_valid, dn_payload, mc_state_o} !== '0) begin
      errors++;
      $display("FAIL reset_second_edge: got v=%0b p=%h mc=%h, expected 0", dn_valid, dn_payload, mc_state_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_advance();
    do_reset();
    stall = '0; flush = 1'b0; up_valid = 1'b1;
    up_payload = 64'h1234; up_inst = 32'h0043_0821; up_mc_state = 66'h3;
    tick();
    checks++;
    if (dn_payload !== 64'h1234 || dn_valid !== 1'b1 || dn_inst !== 32'h0043_0821 || mc_state_o !== '0) begin
      errors++;
      $display("FAIL advance: got v=%0b p=%h i=%h mc=%h, expected v=1 p=1234 i=00430821 mc=0",
               dn_valid, dn_payload, dn_inst, mc_state_o);
    end
    up_valid = 1'b0; up_payload = 64'h0;
    tick();
    checks++;
    if (dn_valid !== 1'b0 || dn_payload !== 64'h0) begin
      errors++;
      $display("FAIL advance_nop: got v=%0b p=%h, expected v=0 p=0", dn_valid, dn_payload);
    end
  endtask

  task automatic test_bubble();
    do_reset();
    stall = '0; up_valid = 1'b1; up_payload = 64'h77; up_inst = 32'hDEAD_BEEF;
    tick();
    stall = 6'b001000; up_mc_state = 66'h5; up_inst = 32'h1111_2222;
    tick();
    checks++;
    if (dn_valid !== 1'b0 || dn_payload !== '0 || dn_inst !== 32'h1111_2222 || mc_state_o !== 66'h5) begin
      errors++;
      $display("FAIL bubble: got v=%0b p=%h i=%h mc=%h, expected v=0 p=0 i=11112222 mc=5",
               dn_valid, dn_payload, dn_inst, mc_state_o);
    end
    checks++;
    if (int'(bubble_cnt) !== exp_bub()) begin
      errors++;
      $display("FAIL bubble_cnt: got %0d expected %0d", bubble_cnt, exp_bub());
    end
    stall = '0;
    tick();
    checks++;
    if (mc_state_o !== '0 || dn_valid !== 1'b1 || dn_payload !== 64'h77) begin
      errors++;
      $display("FAIL bubble_release: got v=%0b p=%h mc=%h, expected v=1 p=77 mc=0", dn_valid, dn_payload, mc_state_o);
    end
  endtask

  task automatic test_hold();
    do_reset();
    stall = '0; up_valid = 1'b1; up_payload = 64'hAB; up_inst = 32'hABAB;
    tick();
    stall = 6'b011000; up_payload = 64'hCC; up_inst = 32'hCCCC;
    for (int i = 0; i < 3; i++) begin
      up_mc_state = MC_W'(i + 9);
      tick();
      checks++;
      if (dn_payload !== 64'hAB || dn_valid !== 1'b1 || dn_inst !== 32'hABAB || mc_state_o !== MC_W'(i + 9)) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%0b p=%h i=%h mc=%h, expected v=1 p=ab i=abab mc=%0d",
                 i, dn_valid, dn_payload, dn_inst, mc_state_o, i + 9);
      end
    end
    checks++;
`ifdef PIPE_PERF_CNT_EN
    if (hold_cnt !== CNT_W'(3)) begin
`else
    if (hold_cnt !== CNT_W'(0)) begin
`endif
      errors++;
      $display("FAIL hold_cnt: got %0d expected %0d", hold_cnt, exp_hold());
    end
    // Flush wins over the hold.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (dn_valid !== 1'b0 || dn_payload !== '0 || mc_state_o !== '0 || dn_inst !== '0) begin
      errors++;
      $display("FAIL flush_in_hold: got v=%0b p=%h i=%h mc=%h, expected all 0", dn_valid, dn_payload, dn_inst, mc_state_o);
    end
    checks++;
    if (int'(hold_cnt) !== exp_hold()) begin
      errors++;
      $display("FAIL flush_cnt: got %0d expected %0d", hold_cnt, exp_hold());
    end
    stall = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    stall = 6'b001000; flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (int'(bubble_cnt) !== exp_bub()) begin
        errors++;
        $display("FAIL sat_cycle[%0d]: got %0d expected %0d", i, bubble_cnt, exp_bub());
      end
    end
    checks++;
`ifdef PIPE_PERF_CNT_EN
    if (bubble_cnt !== CNT_W'(15)) begin
`else
    if (bubble_cnt !== CNT_W'(0)) begin
`endif
      errors++;
      $display("FAIL saturation: got %0d", bubble_cnt);
    end
    stall = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      stall       = STALL_W'($urandom);
      up_valid    = 1'($urandom);
      up_payload  = {$urandom, $urandom};
      up_inst     = $urandom;
      up_mc_state = {2'($urandom), $urandom, $urandom};
      tick();
      checks++;
      if (dn_valid !== m_valid || dn_payload !== m_payload || dn_inst !== m_inst || mc_state_o !== m_mc ||
          int'(bubble_cnt) !== exp_bub() || int'(hold_cnt) !== exp_hold()) begin
        errors++;
        $display("FAIL random[%0d]: got v=%0b p=%h i=%h mc=%h b=%0d h=%0d, expected v=%0b p=%h i=%h mc=%h b=%0d h=%0d",
                 i, dn_valid, dn_payload, dn_inst, mc_state_o, bubble_cnt, hold_cnt,
                 m_valid, m_payload, m_inst, m_mc, exp_bub(), exp_hold());
      end
    end
    rst = 1'b0; flush = 1'b0; stall = '0;
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; up_valid = 1'b0;
    up_payload = '0; up_inst = '0; up_mc_state = '0;
    m_valid = 0; m_payload = '0; m_inst = '0; m_mc = '0; m_bub = 0; m_hold = 0;
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
